// File: rtl/key_adjust_ctrl_if.sv
// Button and adjust-bus bundle shared by the key front-end (master) and the
// per-field time counters (slave).
interface key_adjust_ctrl_if;
  logic [2:0] key_in;
  logic [2:0] adjust;
  logic       key2;
  logic       key3;
  logic       ms_tick;

  modport master (input key_in, output adjust, output key2, output key3, output ms_tick);
  modport slave  (output key_in, input adjust, input key2, input key3, input ms_tick);
endinterface

// File: rtl/key_adjust_ctrl.sv
// Key front-end: synchronise/debounce three buttons, run the adjust-field FSM
// and emit key2/key3 strobes. Define KEY_REPEAT_EN for held-key auto-repeat.
module key_adjust_ctrl #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int FIELD_MAX       = 6,
  parameter int TIMEOUT_S       = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  key_adjust_ctrl_if.master bus
);

  localparam int TICK_CYC = CLK_FREQ / 1000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int TO_MS    = TIMEOUT_S * 1000;
  localparam int TW       = $clog2(TO_MS + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_ADJ = 1'b1} state_t;

  logic [2:0]    key_meta_r;
  logic [2:0]    key_sync_r;
  logic [2:0]    key_lvl_s;
  logic [PW-1:0] pre_cnt_r;
  logic          ms_tick_r;
  logic [DW-1:0] db_cnt_r [3];
  logic [2:0]    db_state_r;
  logic [2:0]    db_prev_r;
  logic [2:0]    press_s;
  logic          press_any_s;
  state_t        state_r;
  state_t        state_nx;
  logic [2:0]    adjust_r;
  logic [2:0]    adjust_nx;
  logic          key2_r;
  logic          key3_r;
  logic          key2_nx;
  logic          key3_nx;
  logic [TW-1:0] to_cnt_r;
  logic          timeout_s;
  logic          rep_fire_s;
  logic          adj_change_s;

  // Two-flop synchroniser; reset value is "released" (raw keys are active low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r <= 3'b111;
      key_sync_r <= 3'b111;
    end else begin
      key_meta_r <= bus.key_in;
      key_sync_r <= key_meta_r;
    end
  end

  assign key_lvl_s = ~key_sync_r;

  // 1 ms prescaler; the tick is registered so it is glitch-free for neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= {PW{1'b0}};
      ms_tick_r <= 1'b0;
    end else if (pre_cnt_r == PW'(TICK_CYC - 1)) begin
      pre_cnt_r <= {PW{1'b0}};
      ms_tick_r <= 1'b1;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1'b1);
      ms_tick_r <= 1'b0;
    end
  end

  // Per-key debounce: a differing level must persist for DEBOUNCE_MS ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state_r <= 3'b000;
      db_prev_r  <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        db_cnt_r[k] <= {DW{1'b0}};
      end
    end else begin
      db_prev_r <= db_state_r;
      for (int k = 0; k < 3; k++) begin
        if (key_lvl_s[k] == db_state_r[k]) begin
          db_cnt_r[k] <= {DW{1'b0}};
        end else if (ms_tick_r) begin
          if (db_cnt_r[k] == DW'(DEBOUNCE_MS - 1)) begin
            db_state_r[k] <= key_lvl_s[k];
            db_cnt_r[k]   <= {DW{1'b0}};
          end else begin
            db_cnt_r[k] <= db_cnt_r[k] + DW'(1'b1);
          end
        end else begin
          db_cnt_r[k] <= db_cnt_r[k];
        end
      end
    end
  end

  assign press_s     = db_state_r & ~db_prev_r;
  assign press_any_s = |press_s;
  assign timeout_s   = (state_r == ST_ADJ) & ms_tick_r & (to_cnt_r == TW'(TO_MS - 1));

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_r;
  logic [RW-1:0] rep_limit_s;
  logic          rep_armed_r;
  logic          rep_hold_s;

  // Only a single held up/down key in ADJ auto-repeats.
  assign rep_hold_s  = (state_r == ST_ADJ) & (db_state_r[1] ^ db_state_r[2]);
  assign rep_limit_s = rep_armed_r ? RW'(REPEAT_RATE_MS - 1) : RW'(REPEAT_DELAY_MS - 1);
  assign rep_fire_s  = rep_hold_s & ms_tick_r & (rep_cnt_r == rep_limit_s);

  // Repeat timer: first interval is the delay, later ones the rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_r   <= {RW{1'b0}};
      rep_armed_r <= 1'b0;
    end else if (!rep_hold_s || press_any_s || adj_change_s) begin
      rep_cnt_r   <= {RW{1'b0}};
      rep_armed_r <= 1'b0;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= {RW{1'b0}};
      rep_armed_r <= 1'b1;
    end else if (ms_tick_r) begin
      rep_cnt_r   <= rep_cnt_r + RW'(1'b1);
      rep_armed_r <= rep_armed_r;
    end else begin
      rep_cnt_r   <= rep_cnt_r;
      rep_armed_r <= rep_armed_r;
    end
  end
`else
  // Repeat disabled: the REPEAT_* parameters only keep the instance interface uniform.
  assign rep_fire_s = 1'b0 && ((REPEAT_DELAY_MS + REPEAT_RATE_MS) > 0);
`endif

  // Next-state and strobe decode; field change beats strobes, any press beats timeout.
  always_comb begin
    state_nx  = state_r;
    adjust_nx = adjust_r;
    key2_nx   = 1'b0;
    key3_nx   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (press_s[0]) begin
          state_nx  = ST_ADJ;
          adjust_nx = 3'd1;
        end else begin
          adjust_nx = 3'd0;
        end
      end
      ST_ADJ: begin
        if (press_s[0]) begin
          if (adjust_r >= 3'(FIELD_MAX)) begin
            state_nx  = ST_RUN;
            adjust_nx = 3'd0;
          end else begin
            adjust_nx = adjust_r + 3'd1;
          end
        end else if (press_s[1] || press_s[2]) begin
          key2_nx = press_s[1] & ~press_s[2];
          key3_nx = press_s[2] & ~press_s[1];
        end else if (rep_fire_s) begin
          key2_nx = db_state_r[1];
          key3_nx = db_state_r[2];
        end else if (timeout_s) begin
          state_nx  = ST_RUN;
          adjust_nx = 3'd0;
        end else begin
          state_nx = ST_ADJ;
        end
      end
      default: begin
        state_nx  = ST_RUN;
        adjust_nx = 3'd0;
      end
    endcase
  end

  assign adj_change_s = (adjust_nx != adjust_r);

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      adjust_r <= 3'd0;
      key2_r   <= 1'b0;
      key3_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      adjust_r <= adjust_nx;
      key2_r   <= key2_nx;
      key3_r   <= key3_nx;
    end
  end

  // Inactivity timer: held at 0 in RUN, restarted by any press or repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_RUN) || press_any_s || rep_fire_s || timeout_s) begin
      to_cnt_r <= {TW{1'b0}};
    end else if (ms_tick_r) begin
      to_cnt_r <= to_cnt_r + TW'(1'b1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign bus.adjust  = adjust_r;
  assign bus.key2    = key2_r;
  assign bus.key3    = key3_r;
  assign bus.ms_tick = ms_tick_r;

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Directed self-checking bench for key_adjust_ctrl (10-cycle ms tick, 2 ms
// debounce, 1 s timeout); the repeat scenario follows KEY_REPEAT_EN.
module tb_key_adjust_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_adjust_ctrl_if bus ();

  key_adjust_ctrl #(
    .CLK_FREQ        (10_000),
    .DEBOUNCE_MS     (2),
    .FIELD_MAX       (6),
    .TIMEOUT_S       (1),
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the model ms tick is high when cyc is a nonzero multiple of 10.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int         n_pass = 0;
  int         n_chk  = 0;
  int         k2_cnt, k3_cnt, chg_cyc, viol, c0, pc, p;
  int         k2_q[$];
  logic [2:0] adj_prev;
  logic       prev2, prev3;
  int         wrap_seq[6] = '{2, 3, 4, 5, 6, 0};
  int         rep_off[5]  = '{0, 49, 69, 89, 109};

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Negedge cyc at which a press driven at negedge cyc c becomes visible on the outputs:
  // sync lands at c+2, two ticks counted from then, debounced edge, then one register stage.
  function automatic int exp_evt(input int c);
    int t;
    t = ((c + 2 + 9) / 10) * 10;
    return t + 12;
  endfunction

  // Hold the masked keys for 'hold' cycles, release, and record what the outputs did.
  task automatic run_keys(input logic [2:0] mask, input int hold);
    k2_cnt  = 0;
    k3_cnt  = 0;
    chg_cyc = -1;
    viol    = 0;
    prev2   = 1'b0;
    prev3   = 1'b0;
    k2_q.delete();
    @(negedge clk);
    c0         = cyc;
    adj_prev   = bus.adjust;
    bus.key_in = 3'b111 & ~mask;
    for (int i = 0; i < hold + 40; i++) begin
      if (i == hold) bus.key_in = 3'b111;
      @(negedge clk);
      if (bus.key2) begin
        k2_cnt++;
        k2_q.push_back(cyc);
        if (prev2) viol = 1;
      end
      if (bus.key3) begin
        k3_cnt++;
        if (prev3) viol = 1;
      end
      if (bus.key2 && bus.key3) viol = 1;
      if ((bus.adjust != adj_prev) && (chg_cyc < 0)) chg_cyc = cyc;
      adj_prev = bus.adjust;
      prev2    = bus.key2;
      prev3    = bus.key3;
    end
  endtask

  initial begin
    bus.key_in = 3'b111;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_adjust", bus.adjust, 0);
    check("rst_key2", bus.key2, 0);
    check("rst_key3", bus.key3, 0);
    check("rst_ms_tick", bus.ms_tick, 0);
    rst_n = 1'b1;
    while (cyc < 9) @(negedge clk);
    check("tick_before", bus.ms_tick, 0);
    @(negedge clk);
    check("tick_at_10", bus.ms_tick, 1);
    @(negedge clk);
    check("tick_after", bus.ms_tick, 0);

    // key1 press enters ADJ with exact latency
    run_keys(3'b001, 50);
    check("key1_latency", chg_cyc, exp_evt(c0));
    check("key1_adjust", bus.adjust, 1);
    check("key1_no_key2", k2_cnt, 0);
    check("key1_no_key3", k3_cnt, 0);

    // Glitch rejection, then a real key2 press
    run_keys(3'b010, 10);
    check("glitch_no_strobe", k2_cnt, 0);
    check("glitch_adjust", bus.adjust, 1);
    run_keys(3'b010, 40);
    check("key2_count", k2_cnt, 1);
    check("key2_time", (k2_q.size() > 0) ? k2_q[0] : -1, exp_evt(c0));
    check("key2_single_cycle", viol, 0);
    check("key2_no_key3", k3_cnt, 0);

    // Field wrap 2..6,0 and key3 discarded in RUN
    for (int i = 0; i < 6; i++) begin
      run_keys(3'b001, 40);
      check("wrap_adjust", bus.adjust, wrap_seq[i]);
    end
    run_keys(3'b100, 40);
    check("run_key3_discard", k3_cnt, 0);
    check("run_key3_adjust", bus.adjust, 0);

    // Timeout from adjust=3 at the 1000th tick after the last press
    for (int i = 0; i < 3; i++) run_keys(3'b001, 40);
    check("to_setup", bus.adjust, 3);
    pc = chg_cyc;
    while (cyc < pc + 9998) @(negedge clk);
    check("to_not_yet", bus.adjust, 3);
    @(negedge clk);
    check("to_fired", bus.adjust, 0);

    // key2 press at 999 ms restarts the timeout
    run_keys(3'b001, 40);
    check("to2_setup", bus.adjust, 1);
    pc = chg_cyc;
    while (cyc < pc + 9967) @(negedge clk);
    run_keys(3'b010, 40);
    p = exp_evt(c0);
    check("to2_press_time", p, pc + 9990);
    check("to2_strobe_count", k2_cnt, 1);
    check("to2_strobe_time", (k2_q.size() > 0) ? k2_q[0] : -1, p);
    check("to2_no_timeout", chg_cyc, -1);
    while (cyc < p + 9998) @(negedge clk);
    check("to2_not_yet", bus.adjust, 1);
    @(negedge clk);
    check("to2_fired", bus.adjust, 0);

    // Simultaneous presses
    run_keys(3'b001, 40);
    run_keys(3'b001, 40);
    check("sim_setup", bus.adjust, 2);
    run_keys(3'b110, 40);
    check("sim23_no_key2", k2_cnt, 0);
    check("sim23_no_key3", k3_cnt, 0);
    check("sim23_adjust", bus.adjust, 2);
    run_keys(3'b011, 40);
    check("sim12_adjust", bus.adjust, 3);
    check("sim12_time", chg_cyc, exp_evt(c0));
    check("sim12_no_key2", k2_cnt, 0);

    // 12 ms hold of key2
    run_keys(3'b010, 120);
    p = exp_evt(c0);
    check("hold_no_overlap", viol, 0);
`ifdef KEY_REPEAT_EN
    check("hold_repeat_count", k2_cnt, 5);
    for (int i = 0; i < 5; i++)
      check("hold_repeat_time", (k2_q.size() > i) ? k2_q[i] : -1, p + rep_off[i]);
`else
    check("hold_single_count", k2_cnt, 1);
    check("hold_single_time", (k2_q.size() > 0) ? k2_q[0] : -1, p + rep_off[0]);
`endif
    check("hold_adjust", bus.adjust, 3);

    // Asynchronous reset while a strobe is high mid-hold
    @(negedge clk);
    c0         = cyc;
    bus.key_in = 3'b101;
    p          = exp_evt(c0);
`ifdef KEY_REPEAT_EN
    p = p + 49;
`endif
    while (cyc < p) @(negedge clk);
    check("pre_reset_strobe", bus.key2, 1);
    check("pre_reset_adjust", bus.adjust, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_adjust", bus.adjust, 0);
    check("midrst_key2", bus.key2, 0);
    check("midrst_key3", bus.key3, 0);
    check("midrst_ms_tick", bus.ms_tick, 0);
    repeat (5) @(negedge clk);
    rst_n  = 1'b1;
    k2_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.key2) k2_cnt++;
    end
    check("held_after_reset_no_key2", k2_cnt, 0);
    check("held_after_reset_adjust", bus.adjust, 0);
    bus.key_in = 3'b111;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
